key_entry_ctrl: RTL

- Consumer end of the keypad key handshake (read_input / key_read) in the 16-bit signed calculator.
- Accepts one decoded key event per handshake: a digit, an operator, or equals.
- Builds signed decimal operands from digits, latches the operator, and issues a start/done transaction to the ALU.
- Holds the current entry or the ALU result for the display path.

---
 rtl/calc_pkg.sv | 50 +++++
 rtl/key_handshake_rx.sv | 73 +++++++
 rtl/key_entry_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator key-entry path: operator codes, entry/handshake states
// and key classification helpers.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_NEG  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        WAIT_ALU,
        SHOW_RES
    } entry_state_t;

    typedef enum logic [1:0] {
        DIGIT,
        NEG,
        OP,
        EQUAL
    } key_kind_t;

    typedef enum logic {
        HS_IDLE,
        HS_ACK
    } hs_state_t;

    // Equals wins over any operator field; everything unrecognised falls through to a digit.
    function automatic key_kind_t classify_key(input logic equal, input logic [2:0] op);
        if (equal) begin
            return EQUAL;
        end else if (op == OP_NEG) begin
            return NEG;
        end else if (op == OP_ADD || op == OP_SUB || op == OP_MUL) begin
            return OP;
        end else begin
            return DIGIT;
        end
    endfunction

    // Operator codes 101-111 are acknowledged but have no effect.
    function automatic logic key_ignored(input logic equal, input logic [2:0] op);
        return !equal && (op > OP_MUL);
    endfunction

endpackage

// File: rtl/key_handshake_rx.sv
// Four-phase keypad acceptor: captures the key fields when ready, holds key_read until
// read_input drops, and emits a single-cycle strobe on the first acknowledge cycle.
module key_handshake_rx
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       read_input,
    input  logic [3:0] keypad_input,
    input  logic [2:0] operator_input,
    input  logic       equal_input,
    input  logic       ready,
    output logic       key_read,
    output logic       key_strobe,
    output logic [3:0] key_digit,
    output logic [2:0] key_op,
    output logic       key_equal
);

    hs_state_t  hs_q, hs_d;
    logic       first_q, first_d;
    logic [3:0] digit_q, digit_d;
    logic [2:0] op_q, op_d;
    logic       equal_q, equal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q    <= HS_IDLE;
            first_q <= 1'b0;
            digit_q <= '0;
            op_q    <= '0;
            equal_q <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            first_q <= first_d;
            digit_q <= digit_d;
            op_q    <= op_d;
            equal_q <= equal_d;
        end
    end

    always_comb begin
        hs_d    = hs_q;
        first_d = 1'b0;
        digit_d = digit_q;
        op_d    = op_q;
        equal_d = equal_q;
        unique case (hs_q)
            HS_IDLE: begin
                if (read_input && ready) begin
                    digit_d = keypad_input;
                    op_d    = operator_input;
                    equal_d = equal_input;
                    first_d = 1'b1;
                    hs_d    = HS_ACK;
                end
            end
            HS_ACK: begin
                if (!read_input) begin
                    hs_d = HS_IDLE;
                end
            end
            default: hs_d = HS_IDLE;
        endcase
    end

    assign key_read   = (hs_q == HS_ACK);
    assign key_strobe = (hs_q == HS_ACK) && first_q;
    assign key_digit  = digit_q;
    assign key_op     = op_q;
    assign key_equal  = equal_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Calculator key-entry controller: builds signed operands from keypad keys and runs one ALU
// transaction per equals. Define KEY_ENTRY_CLEAR_EN to make equals clear the first operand.
module key_entry_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_MAG = 32767
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read_input,
    input  logic [3:0]       keypad_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic             key_read,
    output logic             alu_start,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] display_value,
    output logic             entry_ovf
);

    localparam int unsigned XW = WIDTH + 4;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MaxVal = ~MinVal;

    logic       key_strobe, key_equal, ready;
    logic [3:0] key_digit;
    logic [2:0] key_op;

    key_handshake_rx u_rx (
        .clk            (clk),
        .rst            (rst),
        .read_input     (read_input),
        .keypad_input   (keypad_input),
        .operator_input (operator_input),
        .equal_input    (equal_input),
        .ready          (ready),
        .key_read       (key_read),
        .key_strobe     (key_strobe),
        .key_digit      (key_digit),
        .key_op         (key_op),
        .key_equal      (key_equal)
    );

    // One registered stage between the strobe and the entry FSM.
    logic       kv_q, kign_q;
    key_kind_t  kkind_q;
    logic [3:0] kdig_q;
    logic [2:0] kop_q;

    entry_state_t     entry_q, entry_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic             start_q, start_d;

    logic             key_go, digit_ok;
    logic [XW-1:0]    digit_new;
    logic [WIDTH-1:0] digit_mag, cur_val, disp_neg;
    logic [2:0]       cnt_inc;

    function automatic logic [WIDTH-1:0] entry_value(input logic [WIDTH-1:0] mag,
                                                     input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    // A key is still in the pipeline stage while kv_q is set; hold off the next one.
    assign ready  = (entry_q != WAIT_ALU) && !kv_q;
    assign key_go = kv_q && !kign_q;

    assign digit_new = ({{4{1'b0}}, mag_q} * XW'(10)) + XW'(kdig_q);
    assign digit_ok  = (digit_new <= XW'(MAX_MAG));
    assign digit_mag = digit_ok ? digit_new[WIDTH-1:0] : mag_q;
    assign cur_val   = entry_value(mag_q, neg_q);
    assign cnt_inc   = (cnt_q == 3'b111) ? cnt_q : cnt_q + 3'd1;
    assign disp_neg  = (disp_q == MinVal) ? MaxVal : (~disp_q + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            kv_q    <= 1'b0;
            kign_q  <= 1'b0;
            kkind_q <= DIGIT;
            kdig_q  <= '0;
            kop_q   <= '0;
            entry_q <= ENTER_A;
            mag_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
            start_q <= 1'b0;
        end else begin
            kv_q    <= key_strobe;
            kign_q  <= key_ignored(key_equal, key_op);
            kkind_q <= classify_key(key_equal, key_op);
            kdig_q  <= key_digit;
            kop_q   <= key_op;
            entry_q <= entry_d;
            mag_q   <= mag_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        entry_d = entry_q;
        mag_d   = mag_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        disp_d  = disp_q;
        start_d = 1'b0;
        unique case (entry_q)
            ENTER_A, ENTER_B: begin
                if (key_go) begin
                    unique case (kkind_q)
                        DIGIT: begin
                            mag_d = digit_mag;
                            ovf_d = ovf_q | ~digit_ok;
                            if (digit_ok) begin
                                cnt_d = cnt_inc;
                            end
                        end
                        NEG: neg_d = ~neg_q;
                        OP: begin
                            if (entry_q == ENTER_A) begin
                                a_d     = cur_val;
                                op_d    = kop_q;
                                mag_d   = '0;
                                neg_d   = 1'b0;
                                cnt_d   = '0;
                                ovf_d   = 1'b0;
                                entry_d = ENTER_B;
                            end else if (cnt_q == '0) begin
                                op_d = kop_q;
                            end
                        end
                        EQUAL: begin
                            if (entry_q == ENTER_B) begin
                                b_d     = cur_val;
                                start_d = 1'b1;
                                entry_d = WAIT_ALU;
                            end
`ifdef KEY_ENTRY_CLEAR_EN
                            else begin
                                mag_d = '0;
                                neg_d = 1'b0;
                                cnt_d = '0;
                                ovf_d = 1'b0;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_ALU: begin
                if (alu_done) begin
                    disp_d  = alu_result;
                    entry_d = SHOW_RES;
                end
            end
            SHOW_RES: begin
                if (key_go) begin
                    unique case (kkind_q)
                        DIGIT: begin
                            mag_d   = WIDTH'(kdig_q);
                            neg_d   = 1'b0;
                            cnt_d   = 3'd1;
                            ovf_d   = 1'b0;
                            entry_d = ENTER_A;
                        end
                        OP: begin
                            a_d     = disp_q;
                            op_d    = kop_q;
                            mag_d   = '0;
                            neg_d   = 1'b0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            entry_d = ENTER_B;
                        end
                        NEG: disp_d = disp_neg;
                        default: ;
                    endcase
                end
            end
            default: entry_d = ENTER_A;
        endcase
        // While entering an operand the display tracks it.
        if (entry_d == ENTER_A || entry_d == ENTER_B) begin
            disp_d = entry_value(mag_d, neg_d);
        end
    end

    assign alu_start     = start_q;
    assign alu_op        = op_q;
    assign operand_a     = a_q;
    assign operand_b     = b_q;
    assign display_value = disp_q;
    assign entry_ovf     = ovf_q;

endmodule
